// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared segment patterns, digit codes and scan FSM states for seg_scan_decoder
package seg_scan_pkg;

    localparam logic [6:0] PAT_BLANK = 7'h00;
    localparam logic [6:0] PAT_0     = 7'h3F;
    localparam logic [6:0] PAT_1     = 7'h06;
    localparam logic [6:0] PAT_2     = 7'h5B;
    localparam logic [6:0] PAT_3     = 7'h4F;
    localparam logic [6:0] PAT_4     = 7'h66;
    localparam logic [6:0] PAT_5     = 7'h6D;
    localparam logic [6:0] PAT_6     = 7'h7D;
    localparam logic [6:0] PAT_7     = 7'h07;
    localparam logic [6:0] PAT_7_ALT = 7'h27;
    localparam logic [6:0] PAT_8     = 7'h7F;
    localparam logic [6:0] PAT_9     = 7'h6F;
    localparam logic [6:0] PAT_9_ALT = 7'h67;
    localparam logic [6:0] PAT_HEX_A = 7'h77;
    localparam logic [6:0] PAT_HEX_B = 7'h7C;
    localparam logic [6:0] PAT_HEX_C = 7'h39;
    localparam logic [6:0] PAT_HEX_D = 7'h5E;
    localparam logic [6:0] PAT_HEX_E = 7'h79;
    localparam logic [6:0] PAT_HEX_F = 7'h71;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    typedef enum logic [1:0] {
        ST_WAIT_SEL = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_HOLD     = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - sampled segment/select nets plus reconstructed display outputs
interface seg_scan_decoder_if #(
    parameter int NUM_DIGITS = 8
);
    logic [7:0]              seg_in;
    logic [NUM_DIGITS-1:0]   sel_in;
    logic [4*NUM_DIGITS-1:0] digit_code;
    logic [NUM_DIGITS-1:0]   digit_blank;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [9:0]              value_bin;
    logic                    frame_valid;
    logic                    decode_err;
    logic                    stale;

    modport master (
        output seg_in, sel_in,
        input  digit_code, digit_blank, dp_mask, value_bin, frame_valid, decode_err, stale
    );

    modport slave (
        input  seg_in, sel_in,
        output digit_code, digit_blank, dp_mask, value_bin, frame_valid, decode_err, stale
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - a-g pattern to digit code; hex glyphs only when SEG_HEX_DECODE_EN is defined
module seg7_pattern_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic [3:0] code_o,
    output logic       blank_o,
    output logic       err_o
);
    always_comb begin
        code_o  = CODE_ERR;
        blank_o = 1'b0;
        err_o   = 1'b0;
        case (pat_i)
            PAT_BLANK: begin
                code_o  = CODE_BLANK;
                blank_o = 1'b1;
            end
            PAT_0:            code_o = 4'h0;
            PAT_1:            code_o = 4'h1;
            PAT_2:            code_o = 4'h2;
            PAT_3:            code_o = 4'h3;
            PAT_4:            code_o = 4'h4;
            PAT_5:            code_o = 4'h5;
            PAT_6:            code_o = 4'h6;
            PAT_7, PAT_7_ALT: code_o = 4'h7;
            PAT_8:            code_o = 4'h8;
            PAT_9, PAT_9_ALT: code_o = 4'h9;
`ifdef SEG_HEX_DECODE_EN
            PAT_HEX_A:        code_o = 4'hA;
            PAT_HEX_B:        code_o = 4'hB;
            PAT_HEX_C:        code_o = 4'hC;
            PAT_HEX_D:        code_o = 4'hD;
            PAT_HEX_E:        code_o = 4'hE;
            PAT_HEX_F:        code_o = 4'hF;
`endif
            default:          err_o  = 1'b1;
        endcase
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - samples a multiplexed 7-seg scan bus and republishes stable frames
// Optional hex glyph decode: define SEG_HEX_DECODE_EN.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int SEL_ACTIVE_LOW = 0,
    parameter int SETTLE_CYCLES  = 64,
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_decoder_if.slave bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int FW = $clog2(STABLE_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [FW-1:0] STABLE_MAX = FW'(STABLE_FRAMES);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic [7:0]              seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0]   sel_s1_q, sel_s2_q, sel_q, sel_prev_q, seen_q, seen_d;
    logic [NUM_DIGITS-1:0]   blank_q, err_q, dp_q, prev_blank_q, prev_dp_q;
    logic [NUM_DIGITS-1:0]   out_blank_q, out_dp_q;
    logic [4*NUM_DIGITS-1:0] code_q, prev_code_q, out_code_q;
    logic [9:0]              value_d, out_value_q;
    logic [IW-1:0]           idx_q;
    logic [SW-1:0]           settle_q;
    logic [FW-1:0]           stable_q, stable_d;
    logic [TW-1:0]           tmo_q;
    logic                    frame_valid_q, decode_err_q, stale_q;
    scan_state_t             state_q;

    logic [7:0]            seg_n;
    logic [NUM_DIGITS-1:0] sel_n;
    logic                  sel_valid, sel_change, capture, tmo_fire;
    logic                  frame_full, frame_err, frame_same;
    logic [3:0]            dec_code;
    logic                  dec_blank, dec_err;

    function automatic logic [IW-1:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
        onehot_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (v[i]) onehot_idx = IW'(i);
    endfunction

    function automatic logic [9:0] digit_val(input logic [3:0] c, input logic b);
        return b ? 10'd0 : {6'd0, c};
    endfunction

    assign seg_n      = (SEG_ACTIVE_LOW != 0) ? ~seg_s2_q : seg_s2_q;
    assign sel_n      = (SEL_ACTIVE_LOW != 0) ? ~sel_s2_q : sel_s2_q;
    assign sel_valid  = (sel_n != '0) && ((sel_n & (sel_n - NUM_DIGITS'(1))) == '0);
    assign sel_change = (sel_n != sel_q);
    assign capture    = (state_q == ST_SETTLE) && sel_valid && !sel_change && (settle_q == SETTLE_MAX);
    assign tmo_fire   = (sel_n == sel_prev_q) && (tmo_q == TMO_LAST);
    assign frame_full = (seen_q == '1);
    assign frame_err  = |err_q;
    assign frame_same = (code_q == prev_code_q) && (blank_q == prev_blank_q) && (dp_q == prev_dp_q);
    assign value_d    = digit_val(code_q[3:0], blank_q[0])
                      + 10'd10  * digit_val(code_q[7:4], blank_q[1])
                      + 10'd100 * digit_val(code_q[11:8], blank_q[2]);

    seg7_pattern_decode u_decode (
        .pat_i   (seg_n[6:0]),
        .code_o  (dec_code),
        .blank_o (dec_blank),
        .err_o   (dec_err)
    );

    // A timeout wipes partial progress even if a capture lands in the same cycle.
    always_comb begin
        seen_d = frame_full ? '0 : seen_q;
        if (capture) seen_d[idx_q] = 1'b1;
        if (tmo_fire) seen_d = '0;
        stable_d = FW'(1);
        if (frame_same) stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + FW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q <= '0;  seg_s2_q <= '0;  sel_s1_q <= '0;  sel_s2_q <= '0;
            sel_q <= '0;  sel_prev_q <= '0;  seen_q <= '0;  idx_q <= '0;
            code_q <= '0;  blank_q <= '0;  err_q <= '0;  dp_q <= '0;
            prev_code_q <= '0;  prev_blank_q <= '0;  prev_dp_q <= '0;
            out_code_q <= '0;  out_blank_q <= '0;  out_dp_q <= '0;  out_value_q <= '0;
            settle_q <= '0;  stable_q <= '0;  tmo_q <= '0;
            frame_valid_q <= 1'b0;  decode_err_q <= 1'b0;  stale_q <= 1'b0;
            state_q <= ST_WAIT_SEL;
        end else begin
            seg_s1_q      <= bus.seg_in;
            seg_s2_q      <= seg_s1_q;
            sel_s1_q      <= bus.sel_in;
            sel_s2_q      <= sel_s1_q;
            sel_prev_q    <= sel_n;
            seen_q        <= seen_d;
            frame_valid_q <= 1'b0;
            decode_err_q  <= 1'b0;

            if (sel_n != sel_prev_q)  tmo_q <= '0;
            else if (tmo_q != TMO_MAX) tmo_q <= tmo_q + TW'(1);

            case (state_q)
                ST_WAIT_SEL: if (sel_valid) begin
                    idx_q    <= onehot_idx(sel_n);
                    sel_q    <= sel_n;
                    settle_q <= SW'(1);
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!sel_valid) begin
                        state_q <= ST_WAIT_SEL;
                    end else if (sel_change) begin
                        idx_q    <= onehot_idx(sel_n);
                        sel_q    <= sel_n;
                        settle_q <= SW'(1);
                    end else if (capture) begin
                        code_q[{idx_q, 2'b00} +: 4] <= dec_code;
                        blank_q[idx_q] <= dec_blank;
                        err_q[idx_q]   <= dec_err;
                        dp_q[idx_q]    <= seg_n[7];
                        state_q        <= ST_HOLD;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                ST_HOLD: if (sel_change) begin
                    // The new digit is taken up immediately rather than via WAIT_SEL.
                    if (sel_valid) begin
                        idx_q    <= onehot_idx(sel_n);
                        sel_q    <= sel_n;
                        settle_q <= SW'(1);
                        state_q  <= ST_SETTLE;
                    end else begin
                        state_q <= ST_WAIT_SEL;
                    end
                end
                default: state_q <= ST_WAIT_SEL;
            endcase

            if (tmo_fire) begin
                stale_q  <= 1'b1;
                stable_q <= '0;
            end else if (frame_full) begin
                if (frame_err) begin
                    decode_err_q <= 1'b1;
                    stable_q     <= '0;
                end else begin
                    stable_q     <= stable_d;
                    prev_code_q  <= code_q;
                    prev_blank_q <= blank_q;
                    prev_dp_q    <= dp_q;
                    if (stable_d == STABLE_MAX) begin
                        out_code_q    <= code_q;
                        out_blank_q   <= blank_q;
                        out_dp_q      <= dp_q;
                        out_value_q   <= value_d;
                        frame_valid_q <= 1'b1;
                        stale_q       <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.digit_code  = out_code_q;
    assign bus.digit_blank = out_blank_q;
    assign bus.dp_mask     = out_dp_q;
    assign bus.value_bin   = out_value_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.decode_err  = decode_err_q;
    assign bus.stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - directed and randomized scan frames checked against a frame-level model
module tb_seg_scan_decoder;
    localparam int N      = 8;
    localparam int SETTLE = 4;
    localparam int STABLE = 2;
    localparam int TMO    = 1000;
    localparam int DWELL  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_decoder_if #(.NUM_DIGITS(N)) bus();

    seg_scan_decoder #(
        .NUM_DIGITS(N), .SEG_ACTIVE_LOW(0), .SEL_ACTIVE_LOW(0),
        .SETTLE_CYCLES(SETTLE), .STABLE_FRAMES(STABLE), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0, n_fail = 0;
    int fv_seen = 0, derr_seen = 0, exp_fv = 0, exp_derr = 0;
    int m_stable = 0;
    logic [7:0]     fpat [N];
    logic [7:0]     last_seg = 8'h00;
    logic [6:0]     dig_pat [16];
    logic [4*N-1:0] m_prev_code = '0, exp_code = '0;
    logic [N-1:0]   m_prev_blank = '0, m_prev_dp = '0, exp_blank = '0, exp_dp = '0;
    logic [9:0]     exp_value = '0;
    logic           exp_stale = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.frame_valid) fv_seen++;
            if (bus.decode_err)  derr_seen++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tb_decode(input logic [6:0] p, output logic [3:0] c, output bit b, output bit e);
        int lim;
`ifdef SEG_HEX_DECODE_EN
        lim = 16;
`else
        lim = 10;
`endif
        c = 4'hE; b = 0; e = 1;
        if (p == 7'h00) begin
            c = 4'hF; b = 1; e = 0;
        end else begin
            for (int d = 0; d < lim; d++)
                if (p == dig_pat[d] || (d == 7 && p == 7'h27) || (d == 9 && p == 7'h67)) begin
                    c = d[3:0]; e = 0;
                end
        end
    endtask

    task automatic model_frame();
        logic [4*N-1:0] c;
        logic [N-1:0] b, dp;
        logic [3:0] ci;
        bit bi, ei, any_err;
        int v, w;
        any_err = 0;
        for (int i = 0; i < N; i++) begin
            tb_decode(fpat[i][6:0], ci, bi, ei);
            c[4*i +: 4] = ci; b[i] = bi; dp[i] = fpat[i][7];
            any_err |= ei;
        end
        if (any_err) begin
            exp_derr++;
            m_stable = 0;
        end else begin
            if (c == m_prev_code && b == m_prev_blank && dp == m_prev_dp)
                m_stable = (m_stable < STABLE) ? m_stable + 1 : STABLE;
            else
                m_stable = 1;
            m_prev_code = c; m_prev_blank = b; m_prev_dp = dp;
            if (m_stable == STABLE) begin
                exp_fv++;
                exp_code = c; exp_blank = b; exp_dp = dp; exp_stale = 0;
                v = 0; w = 1;
                for (int k = 0; k < 3; k++) begin
                    if (!b[k]) v += int'(c[4*k +: 4]) * w;
                    w *= 10;
                end
                exp_value = v[9:0];
            end
        end
    endtask

    task automatic set_digits(input logic [31:0] nib);
        for (int i = 0; i < N; i++)
            fpat[i] = (nib[4*i +: 4] == 4'hF) ? 8'h00 : {1'b0, dig_pat[nib[4*i +: 4]]};
    endtask

    task automatic scan_frame(input bit glitch);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            bus.sel_in = '0;
            bus.sel_in[i] = 1'b1;
            if (glitch) begin
                bus.seg_in = last_seg;
                repeat (2) @(negedge clk);
                bus.seg_in = fpat[i];
                repeat (DWELL - 3) @(negedge clk);
            end else begin
                bus.seg_in = fpat[i];
                repeat (DWELL - 1) @(negedge clk);
            end
            last_seg = fpat[i];
        end
        repeat (4) @(negedge clk);
        model_frame();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":fv_count"},   64'(fv_seen),   64'(exp_fv));
        chk({tag, ":derr_count"}, 64'(derr_seen), 64'(exp_derr));
        chk({tag, ":digit_code"}, 64'(bus.digit_code),  64'(exp_code));
        chk({tag, ":digit_blank"},64'(bus.digit_blank), 64'(exp_blank));
        chk({tag, ":dp_mask"},    64'(bus.dp_mask),     64'(exp_dp));
        chk({tag, ":value_bin"},  64'(bus.value_bin),   64'(exp_value));
        chk({tag, ":stale"},      64'(bus.stale),       64'(exp_stale));
    endtask

    initial begin
        int reps, r;
        logic [6:0] p;
        dig_pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        bus.seg_in = 8'h00;
        bus.sel_in = '0;
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset:frame_valid", 64'(bus.frame_valid), 64'd0);
        chk("reset:decode_err",  64'(bus.decode_err),  64'd0);
        rst_n = 1'b1;

        set_digits(32'hFFFFF123);
        scan_frame(0);
        check_all("f123_first");
        scan_frame(0);
        check_all("f123_second");
        chk("f123:code_const",  64'(bus.digit_code),  64'hFFFFF123);
        chk("f123:blank_const", 64'(bus.digit_blank), 64'hF8);
        chk("f123:value_const", 64'(bus.value_bin),   64'd123);

        set_digits(32'hFFFFF045);
        scan_frame(1);
        scan_frame(1);
        check_all("glitch045");
        chk("glitch045:value_const", 64'(bus.value_bin), 64'd45);

        set_digits(32'hFFFFF045);
        fpat[1] = 8'h49;
        scan_frame(0);
        check_all("err49");
        set_digits(32'hFFFFF088);
        scan_frame(0);
        scan_frame(0);
        check_all("f088");
        chk("f088:value_const", 64'(bus.value_bin), 64'd88);

        repeat (880) @(negedge clk);
        chk("tmo:not_yet", 64'(bus.stale), 64'd0);
        repeat (200) @(negedge clk);
        exp_stale = 1'b1;
        m_stable = 0;
        check_all("tmo_hold");
        scan_frame(0);
        check_all("tmo_frame1");
        scan_frame(0);
        check_all("tmo_frame2");

        set_digits(32'hFFFFFFFF);
        fpat[0] = 8'h77;
        scan_frame(0);
        scan_frame(0);
        check_all("hex77");
`ifdef SEG_HEX_DECODE_EN
        chk("hex77:code_a", 64'(bus.digit_code[3:0]), 64'hA);
`else
        chk("hex77:code_kept", 64'(bus.digit_code), 64'hFFFFF088);
`endif

        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 24);
                if (r < 20) begin
                    p = dig_pat[r % 10];
                    if (r % 10 == 7 && $urandom_range(0, 1) == 1) p = 7'h27;
                    if (r % 10 == 9 && $urandom_range(0, 1) == 1) p = 7'h67;
                end else if (r < 24) begin
                    p = 7'h00;
                end else begin
                    p = 7'($urandom);
                end
                fpat[i] = {1'($urandom_range(0, 1)), p};
            end
            reps = $urandom_range(1, 3);
            for (int k = 0; k < reps; k++) begin
                scan_frame(1'($urandom_range(0, 1)));
                check_all($sformatf("rand%0d_%0d", it, k));
            end
        end

        set_digits(32'hFFFFFF42);
        scan_frame(0);
        scan_frame(0);
        check_all("pre_reset");
        @(negedge clk);
        bus.sel_in = 8'h01;
        bus.seg_in = fpat[0];
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_code = '0; exp_blank = '0; exp_dp = '0; exp_value = '0; exp_stale = 1'b0;
        m_prev_code = '0; m_prev_blank = '0; m_prev_dp = '0; m_stable = 0;
        check_all("async_reset");
        chk("async_reset:frame_valid", 64'(bus.frame_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        scan_frame(0);
        check_all("resume1");
        scan_frame(0);
        check_all("resume2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
